// File: rtl/spike_isi_encoder_if.sv
// Event-stream and status bundle of the spike ISI encoder.
// The master side is the encoder; the slave side feeds spikes and consumes events.
interface spike_isi_encoder_if #(
  parameter int unsigned ISI_W  = 8,
  parameter int unsigned RATE_W = 8
);
  logic              spike;
  logic              out_ready;
  logic              out_valid;
  logic [ISI_W-1:0]  out_isi;
  logic              out_sat;
  logic              out_first;
  logic [RATE_W-1:0] rate;
  logic              rate_valid;
  logic [7:0]        drop_cnt;
  logic              overflow;

  modport master (
    input  spike, out_ready,
    output out_valid, out_isi, out_sat, out_first, rate, rate_valid, drop_cnt, overflow
  );

  modport slave (
    output spike, out_ready,
    input  out_valid, out_isi, out_sat, out_first, rate, rate_valid, drop_cnt, overflow
  );
endinterface

// File: rtl/spike_isi_encoder.sv
// Turns a 1-bit spike train into queued inter-spike-interval events and a windowed
// firing-rate sample.
module spike_isi_encoder #(
  parameter int unsigned ISI_W  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIN    = 256,
  parameter int unsigned RATE_W = 8
) (
  input logic clk,
  input logic rst,
  spike_isi_encoder_if.master io_bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(WIN);
  localparam int unsigned EW = ISI_W + 2;
  localparam logic [ISI_W-1:0]  IsiMax  = '1;
  localparam logic [RATE_W-1:0] RateMax = '1;

  logic [ISI_W-1:0]  r_isi;
  logic              r_armed;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic [7:0]        r_drop_cnt;
  logic              r_overflow;
  logic [WW-1:0]     r_win;
  logic [RATE_W-1:0] r_cnt;
  logic [RATE_W-1:0] r_rate;
  logic              r_rate_valid;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [EW-1:0]     w_event;
  logic [EW-1:0]     w_head;
  logic              w_win_last;
  logic [RATE_W-1:0] w_cnt_inc;

  // Extra pointer bit separates full from empty.
  assign w_empty    = (r_wr == r_rd);
  assign w_full     = ((r_wr - r_rd) == (AW + 1)'(DEPTH));
  assign w_pop      = !w_empty && io_bus.out_ready;
  assign w_push     = io_bus.spike && (!w_full || w_pop);
  assign w_drop     = io_bus.spike && w_full && !w_pop;
  assign w_event    = {r_armed, (r_isi == IsiMax), r_isi};
  assign w_head     = r_mem[r_rd[AW-1:0]];
  assign w_win_last = (r_win == WW'(WIN - 1));
  assign w_cnt_inc  = (io_bus.spike && (r_cnt != RateMax)) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_isi   <= '0;
      r_armed <= 1'b1;
    end else if (io_bus.spike) begin
      r_isi   <= ISI_W'(1);
      r_armed <= 1'b0;
    end else if (r_isi != IsiMax) begin
      r_isi   <= r_isi + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hff) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_overflow <= 1'b1;
    end
  end

  // A spike on the last window cycle is folded into the closing sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win        <= '0;
      r_cnt        <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
    end else if (w_win_last) begin
      r_win        <= '0;
      r_cnt        <= '0;
      r_rate       <= w_cnt_inc;
      r_rate_valid <= 1'b1;
    end else begin
      r_win        <= r_win + 1'b1;
      r_cnt        <= w_cnt_inc;
      r_rate_valid <= 1'b0;
    end
  end

  always_comb begin
    io_bus.out_valid  = !w_empty;
    io_bus.out_isi    = w_empty ? '0 : w_head[ISI_W-1:0];
    io_bus.out_sat    = w_empty ? 1'b0 : w_head[ISI_W];
    io_bus.out_first  = w_empty ? 1'b0 : w_head[ISI_W+1];
    io_bus.rate       = r_rate;
    io_bus.rate_valid = r_rate_valid;
    io_bus.drop_cnt   = r_drop_cnt;
    io_bus.overflow   = r_overflow;
  end
endmodule

// File: tb/tb_spike_isi_encoder.sv
// Scoreboard bench for spike_isi_encoder: stimulus pushes hand-computed events,
// a negedge monitor pops and compares on every accepted event or rate pulse.
module tb_spike_isi_encoder;
  typedef struct {
    int isi;
    bit sat;
    bit first;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   rv_cnt = 0;
  ev_t  exp_q[$];
  int   rexp_q[$];

  always #5 clk = ~clk;

  spike_isi_encoder_if bus ();

  spike_isi_encoder dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (bus.rate_valid) begin
        rv_cnt++;
        if (rexp_q.size() > 0) chk("rate", bus.rate, rexp_q.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("event_q_nonempty", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("ev_isi", bus.out_isi, e.isi);
          chk("ev_sat", bus.out_sat, e.sat);
          chk("ev_first", bus.out_first, e.first);
        end
      end
    end
  end

  // One clock: spike sampled at the edge, inputs settle 1 ns after it.
  task automatic step(input logic s);
    bus.spike = s;
    @(posedge clk);
    #1;
    bus.spike = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic spk(input int isi, input bit sat, input bit first);
    ev_t e;
    e.isi = isi;
    e.sat = sat;
    e.first = first;
    exp_q.push_back(e);
    step(1'b1);
  endtask

  // Release lands 1 ns after an edge; the next edge is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    rexp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rv_cnt = 0;
  endtask

  initial begin
    bus.spike = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_isi", bus.out_isi, 0);
    chk("rst_rate", bus.rate, 0);
    chk("rst_rate_valid", bus.rate_valid, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 1'b0;

    // Spikes at cycles 5, 6, 10.
    idle(5);
    chk("lat_before", bus.out_valid, 0);
    spk(5, 0, 1);
    chk("lat_after", bus.out_valid, 1);
    spk(1, 0, 0);
    idle(3);
    spk(4, 0, 0);
    idle(1);
    chk("t1_drained", exp_q.size(), 0);

    // Long gap saturates, then a short gap.
    idle(300);
    spk(255, 1, 0);
    idle(2);
    spk(3, 0, 0);
    idle(1);
    chk("t2_drained", exp_q.size(), 0);

    // Stall: six spikes into a depth-4 FIFO.
    do_reset();
    bus.out_ready = 1'b0;
    idle(2);
    spk(2, 0, 1);
    repeat (3) spk(1, 0, 0);
    step(1'b1);
    step(1'b1);
    chk("t3_drop", bus.drop_cnt, 2);
    chk("t3_ovf", bus.overflow, 1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_isi", bus.out_isi, 2);
      chk("stall_first", bus.out_first, 1);
    end
    // Full FIFO, spike with simultaneous pop: no drop, new event at the tail.
    bus.out_ready = 1'b1;
    spk(4, 0, 0);
    chk("t4_no_drop", bus.drop_cnt, 2);
    idle(4);
    chk("t4_empty", bus.out_valid, 0);
    chk("t4_drained", exp_q.size(), 0);

    // Spike every 4th cycle including window cycle 255.
    do_reset();
    rexp_q.push_back(64);
    rexp_q.push_back(64);
    for (int i = 0; i < 512; i++) begin
      if (i % 4 == 3) spk((i == 3) ? 3 : 4, 0, (i == 3));
      else step(1'b0);
      if (i == 254) chk("rv_early", bus.rate_valid, 0);
      if (i == 255) chk("rv_pulse", bus.rate_valid, 1);
      if (i == 256) chk("rv_once", bus.rate_valid, 0);
    end
    idle(1);
    chk("rv_count", rv_cnt, 2);
    chk("rate_q_drained", rexp_q.size(), 0);

    // Continuous spikes with a stalled sink: rate and drop_cnt saturate.
    do_reset();
    bus.out_ready = 1'b0;
    rexp_q.push_back(255);
    for (int i = 0; i < 300; i++) begin
      if (i < 4) spk((i == 0) ? 0 : 1, 0, (i == 0));
      else step(1'b1);
    end
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    idle(83);
    chk("sat_drop", bus.drop_cnt, 255);
    chk("sat_ovf", bus.overflow, 1);
    chk("sat_rate", bus.rate, 255);
    chk("sat_valid", bus.out_valid, 1);
    chk("sat_rate_q", rexp_q.size(), 0);

    // Mid-stream reset: three events queued, window half elapsed.
    rst = 1'b1;
    exp_q.delete();
    #2;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_isi", bus.out_isi, 0);
    chk("arst_first", bus.out_first, 0);
    chk("arst_rate", bus.rate, 0);
    chk("arst_rate_valid", bus.rate_valid, 0);
    chk("arst_drop", bus.drop_cnt, 0);
    chk("arst_ovf", bus.overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rv_cnt = 0;
    bus.out_ready = 1'b1;
    idle(2);
    spk(2, 0, 1);
    idle(2);
    chk("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
